// File: rtl/half_log2_iterative.sv
// Iterative binary16 log2: exponent gives the integer part, repeated squaring of the
// mantissa yields one fraction bit per clock, then the fixed-point result is packed to binary16.
module half_log2_iterative #(
    parameter int FRAC_BITS = 14,
    parameter int GUARD     = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    input  logic [15:0] a,
    output logic        in_ready,
    output logic        out_valid,
    output logic [15:0] c
);
    localparam int YW = FRAC_BITS + GUARD + 2;  // Q2.(FRAC_BITS+GUARD)
    localparam int VW = 6 + FRAC_BITS;          // {E,F} signed fixed point
    localparam int CW = $clog2(FRAC_BITS + 1);

    typedef enum logic [1:0] {IDLE, ITER, PACK, OUT} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [YW-1:0]        y_q, y_d;
    logic [FRAC_BITS-1:0] f_q, f_d;
    logic [5:0]           e_q, e_d;
    logic                 spec_q, spec_d;
    logic [15:0]          spec_val_q, spec_val_d;
    logic [15:0]          c_q, c_d;

    // operand decode
    logic [4:0]    exp_f;
    logic [9:0]    mant, sub_m;
    logic [3:0]    lz;
    logic [5:0]    dec_e;
    logic [YW-1:0] dec_y;
    logic          dec_spec;
    logic [15:0]   dec_spec_val;

    always_comb begin
        exp_f = a[14:10];
        mant  = a[9:0];
        lz    = 4'd0;
        for (int i = 0; i < 10; i++)
            if (mant[i]) lz = 4'(9 - i);
        sub_m = mant << (lz + 4'd1);
        if (exp_f == 5'd0) begin
            dec_e = 6'd0 - 6'd15 - {2'b00, lz};
            dec_y = {2'b01, sub_m, {(YW-12){1'b0}}};
        end else begin
            dec_e = {1'b0, exp_f} - 6'd15;
            dec_y = {2'b01, mant, {(YW-12){1'b0}}};
        end
        dec_spec     = 1'b0;
        dec_spec_val = 16'h0000;
        if (exp_f == 5'h1f) begin
            dec_spec     = 1'b1;
            dec_spec_val = (mant != 10'd0 || a[15]) ? 16'h7E00 : 16'h7C00;
        end else if (exp_f == 5'd0 && mant == 10'd0) begin
            dec_spec     = 1'b1;
            dec_spec_val = 16'hFC00;
        end else if (a[15]) begin
            dec_spec     = 1'b1;
            dec_spec_val = 16'h7E00;
        end
    end

    // one squaring step; the product is Q4.2(FRAC_BITS+GUARD), realigned back to Q2
    logic [YW-1:0] y_sq, y_next;
    logic          f_bit;

    always_comb begin
        y_sq   = YW'(({{YW{1'b0}}, y_q} * {{YW{1'b0}}, y_q}) >> (FRAC_BITS + GUARD));
        f_bit  = y_sq[YW-1];
        y_next = f_bit ? (y_sq >> 1) : y_sq;
    end

    // pack {E,F} into binary16 with round-to-nearest-even
    logic [VW-1:0] v, mag;
    logic [VW-2:0] norm;
    logic [4:0]    pos, exp_b;
    logic [10:0]   mant_r;
    logic          rnd, sticky, inc;
    logic [15:0]   pack_c;

    always_comb begin
        v   = {e_q, f_q};
        mag = v[VW-1] ? (~v + VW'(1)) : v;
        pos = 5'd0;
        for (int i = 0; i < VW; i++)
            if (mag[i]) pos = 5'(i);
        // leading one lands just above norm, so norm holds only the bits below it
        norm   = (VW-1)'(mag << (5'(VW - 1) - pos));
        rnd    = norm[VW-12];
        sticky = |norm[VW-13:0];
        inc    = rnd & (sticky | norm[VW-11]);
        mant_r = {1'b0, norm[VW-2 -: 10]} + {10'd0, inc};
        exp_b  = pos + 5'd1 + {4'd0, mant_r[10]};
        pack_c = {v[VW-1], exp_b, mant_r[9:0]};
        if (mag == '0)
            pack_c = 16'h0000;
        if (spec_q)
            pack_c = spec_val_q;
    end

    assign in_ready  = (state_q == IDLE) || (state_q == OUT);
    assign out_valid = (state_q == OUT);
    assign c         = c_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        y_d        = y_q;
        f_d        = f_q;
        e_d        = e_q;
        spec_d     = spec_q;
        spec_val_d = spec_val_q;
        c_d        = c_q;
        case (state_q)
            IDLE, OUT: begin
                if (in_valid) begin
                    state_d    = ITER;
                    cnt_d      = '0;
                    y_d        = dec_y;
                    e_d        = dec_e;
                    f_d        = '0;
                    spec_d     = dec_spec;
                    spec_val_d = dec_spec_val;
                end else begin
                    state_d = IDLE;
                end
            end
            ITER: begin
                // the closing ITER cycle only hands the finished F on to PACK
                if (cnt_q == CW'(FRAC_BITS)) begin
                    state_d = PACK;
                end else begin
                    y_d   = y_next;
                    f_d   = {f_q[FRAC_BITS-2:0], f_bit};
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PACK: begin
                state_d = OUT;
                c_d     = pack_c;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            y_q        <= '0;
            f_q        <= '0;
            e_q        <= '0;
            spec_q     <= 1'b0;
            spec_val_q <= 16'h0000;
            c_q        <= 16'h0000;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            y_q        <= y_d;
            f_q        <= f_d;
            e_q        <= e_d;
            spec_q     <= spec_d;
            spec_val_q <= spec_val_d;
            c_q        <= c_d;
        end
    end
endmodule

// File: tb/tb_half_log2_iterative.sv
// Directed bench for half_log2_iterative: values, fixed latency, specials, handshake, reset.
module tb_half_log2_iterative;
    localparam int FRAC_BITS = 14;
    localparam int LAT = FRAC_BITS + 2;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] a = 16'h0000;
    logic        in_ready, out_valid;
    logic [15:0] c;

    int checks = 0;
    int failures = 0;

    half_log2_iterative #(.FRAC_BITS(FRAC_BITS), .GUARD(4)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .a(a),
        .in_ready(in_ready), .out_valid(out_valid), .c(c)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp,
                       input int tol = 0);
        int d;
        checks++;
        d = int'(got) - int'(exp);
        if (d < 0) d = -d;
        if (d > tol) begin
            failures++;
            $display("FAIL %s: got %h expected %h (tol %0d)", tag, got, exp, tol);
        end
    endtask

    task automatic run_op(input string tag, input logic [15:0] op, input logic [15:0] exp,
                          input int tol);
        int lat;
        lat = 999;
        @(negedge clk);
        in_valid = 1'b1;
        a = op;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        chk({tag, "_lat"}, 16'(lat), 16'(LAT));
        chk(tag, c, exp, tol);
        @(posedge clk);
        #1 chk({tag, "_pulse"}, {15'd0, out_valid}, 16'd0);
    endtask

    initial begin
        int acc2, out0, out1, nout, rdy_out0, rdy_iter, outs_after_rst;
        logic [15:0] res0, res1;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {15'd0, in_ready}, 16'd1);
        chk("rst_valid", {15'd0, out_valid}, 16'd0);
        chk("rst_c", c, 16'h0000);
        @(negedge clk) rstn = 1'b1;

        // values
        run_op("log_8",       16'h4800, 16'h4200, 0);
        run_op("log_1",       16'h3C00, 16'h0000, 0);
        run_op("log_half",    16'h3800, 16'hBC00, 0);
        run_op("log_minsub",  16'h0001, 16'hCE00, 0);
        run_op("log_3",       16'h4200, 16'h3E57, 1);
        run_op("log_max",     16'h7BFF, 16'h4C00, 0);
        run_op("log_sub200",  16'h0200, 16'hCB80, 0);  // 2^-15 -> -15.0
        // specials
        run_op("sp_pzero",    16'h0000, 16'hFC00, 0);
        run_op("sp_nzero",    16'h8000, 16'hFC00, 0);
        run_op("sp_neg",      16'hC000, 16'h7E00, 0);
        run_op("sp_pinf",     16'h7C00, 16'h7C00, 0);
        run_op("sp_ninf",     16'hFC00, 16'h7E00, 0);
        run_op("sp_nan",      16'h7E01, 16'h7E00, 0);

        // handshake: in_valid held high, operand switched right after the first accept
        acc2 = -1; out0 = -1; out1 = -1; nout = 0; rdy_out0 = 0; rdy_iter = 1;
        res0 = 16'hxxxx; res1 = 16'hxxxx;
        @(negedge clk);
        in_valid = 1'b1;
        a = 16'h4800;
        @(posedge clk);
        #1 a = 16'h3800;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc == 5) rdy_iter = int'(in_ready);
            if (acc2 == cyc) in_valid = 1'b0;
            if (out_valid) begin
                if (nout == 0) begin
                    out0 = cyc; res0 = c; rdy_out0 = int'(in_ready);
                    if (in_ready && in_valid) acc2 = cyc + 1;
                end else if (nout == 1) begin
                    out1 = cyc; res1 = c;
                end
                nout++;
            end
        end
        in_valid = 1'b0;
        chk("hs_iter_busy", 16'(rdy_iter), 16'd0);
        chk("hs_out0_lat", 16'(out0), 16'(LAT));
        chk("hs_res0", res0, 16'h4200);
        chk("hs_ready_out", 16'(rdy_out0), 16'd1);
        chk("hs_out1_lat", 16'(out1 - acc2), 16'(LAT));
        chk("hs_res1", res1, 16'hBC00);
        chk("hs_count", 16'(nout), 16'd2);

        // reset mid-ITER
        @(negedge clk);
        in_valid = 1'b1;
        a = 16'h4800;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk) rstn = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_ready", {15'd0, in_ready}, 16'd1);
        chk("mid_rst_c", c, 16'h0000);
        @(negedge clk) rstn = 1'b1;
        outs_after_rst = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1 if (out_valid) outs_after_rst++;
        end
        chk("mid_rst_no_out", 16'(outs_after_rst), 16'd0);
        run_op("post_rst_3", 16'h4200, 16'h3E57, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
